// File: rtl/spart_tx_pkg.sv
// Shared definitions for the SPART transmitter: state encoding and defaults.
package spart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Default enable pulses per bit; the receiver and the baud generator use the same value.
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;
  localparam int STOP_BITS_DEF  = 1;

endpackage

// File: rtl/spart_tx.sv
// SPART transmit half: double-buffered 8N1 serialiser paced by the 16x baud enable.
//
//  state | meaning
//  IDLE  | line idle high, waiting for the holding register to fill
//  START | start bit (low) on the wire
//  DATA  | payload bits, LSB first
//  STOP  | stop bit(s) high; may chain straight into the next START
module spart_tx
  import spart_tx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int STOP_BITS  = STOP_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 tx_load,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 txd,
  output logic                 tbr,
  output logic                 tx_busy
);

  localparam int EN_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS + 1);
  localparam logic [EN_W-1:0] EN_LAST   = EN_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0] STOP_LAST = BC_W'(STOP_BITS - 1);

  tx_state_e            state;
  logic [EN_W-1:0]      en_cnt;
  logic [BC_W-1:0]      bit_cnt;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;
  logic [DATA_BITS-1:0] shift;

  logic bit_end;
  logic frame_done;
  logic xfer;

  assign bit_end    = enable && (en_cnt == EN_LAST);
  assign frame_done = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);
  // A held byte moves to the shifter from IDLE or straight off the last stop bit.
  assign xfer       = hold_full && ((state == IDLE) || frame_done);

  assign tbr     = ~hold_full;
  assign tx_busy = (state != IDLE);

  // Holding register: accept a byte only while empty, release it on transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      if (xfer) begin
        hold_full <= 1'b0;
      end
      if (tx_load && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
      end
    end
  end

  // Frame sequencing: state, oversample counter and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      en_cnt  <= '0;
      bit_cnt <= '0;
    end else if (xfer) begin
      // Start bit is aligned to clk, so the oversample count restarts here.
      state   <= START;
      en_cnt  <= '0;
      bit_cnt <= '0;
    end else begin
      if (state != IDLE && enable) begin
        en_cnt <= bit_end ? '0 : en_cnt + 1'b1;
      end
      case (state)
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == DATA_LAST) begin
              state   <= STOP;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          // Stop bits reuse bit_cnt to count STOP_BITS bit times.
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              state   <= IDLE;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Shifter and registered line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      txd   <= 1'b1;
      shift <= '0;
    end else if (xfer) begin
      shift <= hold_data;
      txd   <= 1'b0;
    end else if (bit_end) begin
      case (state)
        START: txd <= shift[0];
        DATA: begin
          if (bit_cnt == DATA_LAST) begin
            txd <= 1'b1;
          end else begin
            shift <= shift >> 1;
            txd   <= shift[1];
          end
        end
        STOP:    txd <= 1'b1;
        default: txd <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_tx.sv
// Self-checking bench for spart_tx: directed frame vectors, corner sequences and a
// randomized loopback against a bench-side bit-sampling receiver.
module tb_spart_tx;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // line bits in time order: [0]=start, [8:1]=data, [9]=stop
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       tx_load = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       txd;
  logic       tbr;
  logic       tx_busy;

  int total = 0;
  int bad   = 0;

  spart_tx dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .tx_load (tx_load),
    .tx_data (tx_data),
    .txd     (txd),
    .tbr     (tbr),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  // Baud enable: one pulse every en_div clocks, gated by en_on.
  int en_div = 4;
  bit en_on  = 1'b1;
  int div    = 0;
  always @(negedge clk) begin
    div    = (div + 1) % en_div;
    enable = en_on && (div == 0);
  end

  // Reference receiver: finds the start edge, samples mid-bit at a fixed clock
  // spacing, and collects decoded bytes.
  int         bit_clk = 64;
  bit         rx_on = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] rx_b;
  int         rx_stop_bad = 0;
  always begin
    @(negedge clk);
    if (rx_on && txd === 1'b0) begin
      repeat (bit_clk / 2 - 1) @(negedge clk);
      if (txd === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (bit_clk) @(negedge clk);
          rx_b[i] = txd;
        end
        repeat (bit_clk) @(negedge clk);
        if (txd !== 1'b1) rx_stop_bad++;
        rx_q.push_back(rx_b);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int n = 0;
    while (tx_busy !== 1'b0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) begin
      total++;
      bad++;
      $display("FAIL %s: tx_busy still high after %0d clk, expected 0", nm, lim);
    end
  endtask

  // Called at the first negedge after txd fell (minus 'pre' negedges already spent).
  // Samples every bit mid-window; optionally stalls enable for 200 clk after bit stall_bit.
  task automatic check_frame(input logic [9:0] fr, input int stall_bit, input string nm,
                             input int pre);
    tick(bit_clk / 2 - 1 - pre);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick(bit_clk);
      chk($sformatf("%s_bit%0d", nm, k), txd, fr[k]);
      if (k == stall_bit) begin
        logic h;
        int   ch;
        int   idle_seen;
        h = txd;
        ch = 0;
        idle_seen = 0;
        en_on = 1'b0;
        repeat (200) begin
          @(negedge clk);
          if (txd !== h) ch++;
          if (tx_busy !== 1'b1) idle_seen++;
        end
        en_on = 1'b1;
        chk({nm, "_steady"}, ch, 0);
        chk({nm, "_busy_held"}, idle_seen, 0);
      end
    end
  endtask

  initial begin
    vec_t       tbl[4];
    logic [7:0] sent[$];
    logic [7:0] d;
    int         n;
    int         gap;

    tbl[0] = '{8'hA5, 10'b1101001010};
    tbl[1] = '{8'h00, 10'b1000000000};
    tbl[2] = '{8'hFF, 10'b1111111110};
    tbl[3] = '{8'h3C, 10'b1001111000};

    // Reset state
    rst = 1'b1;
    tick(3);
    chk("rst_txd", txd, 1);
    chk("rst_tbr", tbr, 1);
    chk("rst_busy", tx_busy, 0);
    rst = 1'b0;
    tick(2);

    // Directed frames: latency, bit order, frame length
    for (int i = 0; i < 4; i++) begin
      load(tbl[i].data);
      chk("lat_tbr_low", tbr, 0);
      chk("lat_txd_high", txd, 1);
      @(negedge clk);
      chk("lat_txd_low", txd, 0);
      chk("lat_tbr_back", tbr, 1);
      chk("lat_busy", tx_busy, 1);
      check_frame(tbl[i].frame, -1, $sformatf("vec%0d", i), 0);
      chk("busy_in_stop", tx_busy, 1);
      tick(40);
      chk("busy_drop", tx_busy, 0);
      chk("idle_txd", txd, 1);
      tick(10);
    end

    // Back-to-back: second byte queued as soon as tbr returns
    load(8'h00);
    @(negedge clk);
    chk("b2b_tbr_up", tbr, 1);
    load(8'hFF);
    chk("b2b_held", tbr, 0);
    check_frame(10'b1000000000, -1, "b2b_a", 1);
    n = 0;
    gap = 0;
    while (txd !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
      if (tx_busy !== 1'b1) gap++;
    end
    chk("b2b_idle_cycles", gap, 0);
    chk("b2b_found_start", (n < 40), 1);
    check_frame(10'b1111111110, -1, "b2b_b", 0);
    wait_idle("b2b_end", 100);
    tick(10);

    // Load while tbr=0 is dropped
    rx_q.delete();
    rx_on = 1'b1;
    load(8'h11);
    @(negedge clk);
    load(8'h22);
    tick(100);
    chk("drop_tbr_low", tbr, 0);
    load(8'h33);
    wait_idle("drop_end", 3000);
    tick(20);
    chk("drop_tbr_empty", tbr, 1);
    chk("drop_count", rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      chk("drop_byte0", rx_q[0], 8'h11);
      chk("drop_byte1", rx_q[1], 8'h22);
    end
    tick(700);
    chk("drop_no_third", tx_busy, 0);
    chk("drop_count_after", rx_q.size(), 2);
    rx_on = 1'b0;

    // Reset in the middle of data bit 3, then a clean frame
    load(8'h96);
    @(negedge clk);
    tick(31 + 64 * 4);
    chk("mrst_busy_before", tx_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_txd", txd, 1);
    chk("mrst_tbr", tbr, 1);
    chk("mrst_busy", tx_busy, 0);
    tick(5);
    rx_q.delete();
    rx_on = 1'b1;
    load(8'h3C);
    @(negedge clk);
    chk("mrst_restart_low", txd, 0);
    check_frame(10'b1001111000, -1, "mrst_3c", 0);
    wait_idle("mrst_end", 100);
    tick(20);
    chk("mrst_rx_count", rx_q.size(), 1);
    if (rx_q.size() >= 1) chk("mrst_rx_byte", rx_q[0], 8'h3C);
    rx_on = 1'b0;

    // Enable stall mid-bit freezes the line
    load(8'h69);
    @(negedge clk);
    check_frame(10'b1011010010, 3, "stall", 0);
    wait_idle("stall_end", 100);
    tick(10);

    // Randomized loopback at one enable per clk (16 clk per bit)
    en_div  = 1;
    bit_clk = 16;
    tick(4);
    rx_q.delete();
    rx_on = 1'b1;
    for (int i = 0; i < 256; i++) begin
      n = 0;
      while (tbr !== 1'b1 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 1000) begin
        total++;
        bad++;
        $display("FAIL loop_tbr_wait: tbr low for %0d clk, expected 1", n);
      end
      d = 8'($urandom_range(0, 255));
      load(d);
      sent.push_back(d);
    end
    wait_idle("loop_end", 1000);
    tick(40);
    chk("loop_count", rx_q.size(), sent.size());
    for (int i = 0; i < 256; i++) begin
      if (i < rx_q.size()) chk($sformatf("loop_byte%0d", i), rx_q[i], sent[i]);
    end
    chk("rx_stop_bits", rx_stop_bad, 0);
    rx_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
